// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: merges two never-stalled ALU lanes and a FIFO-buffered
// long-latency source onto the register file's two write ports. Buffered
// results that a younger ALU write to the same register supersedes are popped
// without writing.
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu0_valid,
    input  logic [AW-1:0]            alu0_rd,
    input  logic [DW-1:0]            alu0_data,
    input  logic                     alu1_valid,
    input  logic [AW-1:0]            alu1_rd,
    input  logic [DW-1:0]            alu1_data,
    input  logic                     ll_valid,
    input  logic [AW-1:0]            ll_rd,
    input  logic [DW-1:0]            ll_data,
    output logic                     ll_ready,
    output logic                     we1,
    output logic [AW-1:0]            writeRegister1,
    output logic [DW-1:0]            writeData1,
    output logic                     we2,
    output logic [AW-1:0]            writeRegister2,
    output logic [DW-1:0]            writeData2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);

    // FIFO storage and bookkeeping
    logic [AW-1:0]    entRd_q   [DEPTH];
    logic [DW-1:0]    entData_q [DEPTH];
    logic [DEPTH-1:0] entLive_q, entLive_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW:0]      count_q, count_d;

    // Registered write-port outputs
    logic             we1_q, we1_d;
    logic [AW-1:0]    wreg1_q, wreg1_d;
    logic [DW-1:0]    wdata1_q, wdata1_d;
    logic             we2_q, we2_d;
    logic [AW-1:0]    wreg2_q, wreg2_d;
    logic [DW-1:0]    wdata2_q, wdata2_d;

    // Per-cycle decode
    logic             aluIss0, aluIss1;
    logic             llPush;
    logic [PW-1:0]    headIdx, secIdx;
    logic             haveHead, haveSec;
    logic             killHead;
    logic [1:0]       popCnt;

    // True when an issuing ALU lane targets rd this cycle (rd==0 never issues)
    function automatic logic aluHits(
        input logic [AW-1:0] rd,
        input logic          v0,
        input logic [AW-1:0] r0,
        input logic          v1,
        input logic [AW-1:0] r1
    );
        return (v0 && (r0 == rd)) || (v1 && (r1 == rd));
    endfunction

    assign ll_ready       = (count_q < (PW+1)'(DEPTH));
    assign fifo_count     = count_q;
    assign we1            = we1_q;
    assign writeRegister1 = wreg1_q;
    assign writeData1     = wdata1_q;
    assign we2            = we2_q;
    assign writeRegister2 = wreg2_q;
    assign writeData2     = wdata2_q;

    // Port assignment, pop count, WAW kill marking and FIFO next state
    always_comb begin
        aluIss0  = alu0_valid && (alu0_rd != '0);
        aluIss1  = alu1_valid && (alu1_rd != '0);
        llPush   = ll_valid && ll_ready && (ll_rd != '0);
        headIdx  = rdPtr_q;
        secIdx   = rdPtr_q + PW'(1);
        haveHead = (count_q != '0);
        haveSec  = (count_q >= (PW+1)'(2));
        killHead = aluHits(entRd_q[headIdx], aluIss0, alu0_rd, aluIss1, alu1_rd);

        popCnt   = 2'd0;
        we1_d    = 1'b0;
        wreg1_d  = '0;
        wdata1_d = '0;
        we2_d    = 1'b0;
        wreg2_d  = '0;
        wdata2_d = '0;

        if (aluIss0 && aluIss1) begin
            we1_d    = 1'b1;
            wreg1_d  = alu0_rd;
            wdata1_d = alu0_data;
            we2_d    = 1'b1;
            wreg2_d  = alu1_rd;
            wdata2_d = alu1_data;
        end else if (aluIss0 || aluIss1) begin
            we2_d    = 1'b1;
            wreg2_d  = aluIss0 ? alu0_rd : alu1_rd;
            wdata2_d = aluIss0 ? alu0_data : alu1_data;
            if (haveHead) begin
                popCnt = 2'd1;
                if (entLive_q[headIdx] && !killHead) begin
                    we1_d    = 1'b1;
                    wreg1_d  = entRd_q[headIdx];
                    wdata1_d = entData_q[headIdx];
                end
            end
        end else begin
            if (haveHead) begin
                popCnt = 2'd1;
                if (entLive_q[headIdx]) begin
                    we1_d    = 1'b1;
                    wreg1_d  = entRd_q[headIdx];
                    wdata1_d = entData_q[headIdx];
                end
            end
            if (haveSec) begin
                popCnt = 2'd2;
                if (entLive_q[secIdx]) begin
                    we2_d    = 1'b1;
                    wreg2_d  = entRd_q[secIdx];
                    wdata2_d = entData_q[secIdx];
                end
            end
        end

        entLive_d = entLive_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (aluHits(entRd_q[i], aluIss0, alu0_rd, aluIss1, alu1_rd)) begin
                entLive_d[i] = 1'b0;
            end
        end
        if (llPush) begin
            entLive_d[wrPtr_q] = !aluHits(ll_rd, aluIss0, alu0_rd, aluIss1, alu1_rd);
        end

        rdPtr_d = rdPtr_q + PW'(popCnt);
        wrPtr_d = wrPtr_q + PW'(llPush);
        count_d = count_q + (PW+1)'(llPush) - (PW+1)'(popCnt);
    end

    // State update; reset drops every buffered entry and clears the write ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entRd_q[i]   <= '0;
                entData_q[i] <= '0;
            end
            entLive_q <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            we1_q     <= 1'b0;
            wreg1_q   <= '0;
            wdata1_q  <= '0;
            we2_q     <= 1'b0;
            wreg2_q   <= '0;
            wdata2_q  <= '0;
        end else begin
            if (llPush) begin
                entRd_q[wrPtr_q]   <= ll_rd;
                entData_q[wrPtr_q] <= ll_data;
            end
            entLive_q <= entLive_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            we1_q     <= we1_d;
            wreg1_q   <= wreg1_d;
            wdata1_q  <= wdata1_d;
            we2_q     <= we2_d;
            wreg2_q   <= wreg2_d;
            wdata2_q  <= wdata2_d;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter with a small register-file model that
// commits both write ports on the negedge, port 2 last.
module tb_wb_write_arbiter;

    logic        clk;
    logic        rst;
    logic        alu0_valid;
    logic [4:0]  alu0_rd;
    logic [31:0] alu0_data;
    logic        alu1_valid;
    logic [4:0]  alu1_rd;
    logic [31:0] alu1_data;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        ll_ready;
    logic        we1;
    logic [4:0]  writeRegister1;
    logic [31:0] writeData1;
    logic        we2;
    logic [4:0]  writeRegister2;
    logic [31:0] writeData2;
    logic [2:0]  fifo_count;

    int          checks = 0;
    int          errors = 0;
    int          r0Hits = 0;
    logic [31:0] regFile [32];

    wb_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu0_valid     (alu0_valid),
        .alu0_rd        (alu0_rd),
        .alu0_data      (alu0_data),
        .alu1_valid     (alu1_valid),
        .alu1_rd        (alu1_rd),
        .alu1_data      (alu1_data),
        .ll_valid       (ll_valid),
        .ll_rd          (ll_rd),
        .ll_data        (ll_data),
        .ll_ready       (ll_ready),
        .we1            (we1),
        .writeRegister1 (writeRegister1),
        .writeData1     (writeData1),
        .we2            (we2),
        .writeRegister2 (writeRegister2),
        .writeData2     (writeData2),
        .fifo_count     (fifo_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: port 1 then port 2 so the younger write wins
    always @(negedge clk) begin
        if (we1) regFile[writeRegister1] = writeData1;
        if (we2) regFile[writeRegister2] = writeData2;
        if ((we1 && writeRegister1 == 5'd0) || (we2 && writeRegister2 == 5'd0)) r0Hits++;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Compare both write ports; destination/data only matter when a write is expected
    task automatic checkWrite(input string tag,
                              input logic e1, input logic [4:0] r1, input logic [31:0] d1,
                              input logic e2, input logic [4:0] r2, input logic [31:0] d2);
        checkOutput({tag, " we1"}, 32'(we1), 32'(e1));
        if (e1) begin
            checkOutput({tag, " rd1"}, 32'(writeRegister1), 32'(r1));
            checkOutput({tag, " data1"}, writeData1, d1);
        end
        checkOutput({tag, " we2"}, 32'(we2), 32'(e2));
        if (e2) begin
            checkOutput({tag, " rd2"}, 32'(writeRegister2), 32'(r2));
            checkOutput({tag, " data2"}, writeData2, d2);
        end
    endtask

    // Drive one cycle of sources at the negedge, return 1ns after the posedge
    task automatic applyStimulus(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        @(negedge clk);
        alu0_valid = v0; alu0_rd = r0; alu0_data = d0;
        alu1_valid = v1; alu1_rd = r1; alu1_data = d1;
        ll_valid   = lv; ll_rd   = lr; ll_data   = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Reset-state check shared by power-on and mid-stream reset
    task automatic checkReset(input string tag);
        checkWrite(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput({tag, " rd1"}, 32'(writeRegister1), 32'd0);
        checkOutput({tag, " data1"}, writeData1, 32'd0);
        checkOutput({tag, " rd2"}, 32'(writeRegister2), 32'd0);
        checkOutput({tag, " data2"}, writeData2, 32'd0);
        checkOutput({tag, " count"}, 32'(fifo_count), 32'd0);
        checkOutput({tag, " ready"}, 32'(ll_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regFile[i] = 32'd0;
        rst = 1'b0;
        alu0_valid = 1'b0; alu0_rd = 5'd0; alu0_data = 32'd0;
        alu1_valid = 1'b0; alu1_rd = 5'd0; alu1_data = 32'd0;
        ll_valid   = 1'b0; ll_rd   = 5'd0; ll_data   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("por");
        @(negedge clk);
        rst = 1'b1;

        // Two ALU lanes to the same register
        applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
        checkWrite("dual", 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        idleCycle();
        checkWrite("dual idle", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("dual r5", regFile[5], 32'h22);

        // Fill the FIFO while both ALU lanes are busy
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'd10, 32'h1000 + 32'(i), 1'b1, 5'd11, 32'h2000 + 32'(i),
                          1'b1, 5'(i), 32'h100 + 32'(i));
            checkWrite("fill", 1'b1, 5'd10, 32'h1000 + 32'(i), 1'b1, 5'd11, 32'h2000 + 32'(i));
            checkOutput("fill count", 32'(fifo_count), 32'(i));
        end
        checkOutput("full ready", 32'(ll_ready), 32'd0);
        // A push offered while full must be refused even though two entries pop
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h20);
        checkWrite("drain1", 1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102);
        checkOutput("drain1 count", 32'(fifo_count), 32'd2);
        checkOutput("drain1 ready", 32'(ll_ready), 32'd1);
        idleCycle();
        checkWrite("drain2", 1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104);
        checkOutput("drain2 count", 32'(fifo_count), 32'd0);

        // WAW kill of a buffered entry by a younger ALU write
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        checkWrite("waw push", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("waw push count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
        checkWrite("waw kill", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBB);
        checkOutput("waw kill count", 32'(fifo_count), 32'd0);

        // Entry enqueued in the same cycle as a matching ALU write is born dead
        applyStimulus(1'b1, 5'd8, 32'hC2, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hC1);
        checkWrite("waw same", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hC2);
        checkOutput("waw same count", 32'(fifo_count), 32'd1);
        checkOutput("waw r7", regFile[7], 32'hBB);
        idleCycle();
        checkWrite("waw dead pop", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("waw dead count", 32'(fifo_count), 32'd0);
        checkOutput("waw r8", regFile[8], 32'hC2);

        // r0 filtering and a push coinciding with a pop
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
        checkOutput("r0 ll count", 32'(fifo_count), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h12C);
        checkOutput("pp pre count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        checkWrite("pushpop", 1'b1, 5'd12, 32'h12C, 1'b1, 5'd13, 32'hD);
        checkOutput("pushpop count", 32'(fifo_count), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
        checkWrite("pop rd9", 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        checkOutput("pop rd9 count", 32'(fifo_count), 32'd0);
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd14, 32'hE, 1'b1, 5'd0, 32'hF00D);
        checkWrite("r0 alu", 1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hE);

        // Pointer wrap: one push and one pop per cycle, ten entries
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'(i), 1'b1, 5'(16 + i), 32'h200 + 32'(i));
            if (i == 0) checkWrite("wrap", 1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'(i));
            else        checkWrite("wrap", 1'b1, 5'(15 + i), 32'h1FF + 32'(i), 1'b1, 5'd30, 32'(i));
            checkOutput("wrap count", 32'(fifo_count), 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'd10, 1'b0, 5'd0, 32'd0);
        checkWrite("wrap last", 1'b1, 5'd25, 32'h209, 1'b1, 5'd30, 32'd10);
        checkOutput("wrap last count", 32'(fifo_count), 32'd0);

        // Asynchronous reset with three entries buffered
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 5'd10, 32'h3000, 1'b1, 5'd11, 32'h4000, 1'b1, 5'(i), 32'h500 + 32'(i));
        end
        checkOutput("mid pre count", 32'(fifo_count), 32'd3);
        #2;
        rst = 1'b0;
        alu0_valid = 1'b0; alu1_valid = 1'b0; ll_valid = 1'b0;
        #1;
        checkReset("mid rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            checkWrite("post rst", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checkOutput("post rst count", 32'(fifo_count), 32'd0);
        end
        checkOutput("r1 not stale", regFile[1], 32'h101);
        checkOutput("r0 writes", 32'(r0Hits), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
